// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the key input controller: arbiter FSM states,
// logical key indices and the debounce counter width.
package input_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2
  } arb_state_t;

  localparam int KEY_JUMP  = 0;
  localparam int KEY_DUCK  = 1;
  localparam int KEY_PAUSE = 2;
  localparam int KEY_START = 3;

  localparam int DEB_CNT_W = 4;

endpackage

// File: rtl/key_debounce.sv
// One key lane: synchronizes the raw key level, counts consecutive frame
// ticks on which it reads high, and pulses press on the tick where the
// count first reaches DEBOUNCE_FRAMES.
module key_debounce
  import input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic frame_tick,
  input  logic key_raw,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] TARGET    = DEB_CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [DEB_CNT_W-1:0] ARM_LEVEL = DEB_CNT_W'(DEBOUNCE_FRAMES - 1);

  logic                 key_meta;
  logic                 key_sync;
  logic [DEB_CNT_W-1:0] count;

  // Two-flop synchronizer for the asynchronous key level
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
    end
  end

  // Saturating run-length of high samples, evaluated only on frame ticks
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (frame_tick) begin
      if (!key_sync) begin
        count <= '0;
      end else if (count != TARGET) begin
        count <= count + 1'b1;
      end
    end
  end

  // A held key yields a single event: only the step into TARGET counts
  assign press = frame_tick & key_sync & (count == ARM_LEVEL);

endmodule

// File: rtl/key_interrupt_arbiter.sv
// Debounced key interrupt arbiter: latches key presses into pending bits and
// serves them lowest-index first through an irq/irq_ack handshake, with a
// one-cycle gap guaranteeing a distinct irq edge for every press.
module key_interrupt_arbiter
  import input_ctrl_pkg::*;
#(
  parameter  int NUM_KEYS        = 4,
  parameter  int DEBOUNCE_FRAMES = 2,
  localparam int CODE_W          = $clog2(NUM_KEYS)
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                frame_rt_clk,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] key_mask,
  output logic                irq,
  output logic [CODE_W-1:0]   irq_code,
  input  logic                irq_ack,
  output logic [NUM_KEYS-1:0] pending,
  output logic                overrun,
  input  logic                overrun_clr
);

  logic                frame_meta;
  logic                frame_sync;
  logic                frame_prev;
  logic [1:0]          sync_fill;
  logic                tick_armed;
  logic                frame_tick;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] press_enabled;
  logic [NUM_KEYS-1:0] sel_onehot;
  logic [NUM_KEYS-1:0] sel_clear;
  logic [CODE_W-1:0]   sel_idx;
  logic                lost;
  arb_state_t          state;

  // Frame clock synchronizer and rise detector; ticks are only armed once a
  // genuine low level has been seen, so a high level at release is no edge
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frame_meta <= 1'b0;
      frame_sync <= 1'b0;
      frame_prev <= 1'b0;
      sync_fill  <= '0;
      tick_armed <= 1'b0;
    end else begin
      frame_meta <= frame_rt_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;
      sync_fill  <= {sync_fill[0], 1'b1};
      tick_armed <= tick_armed | (sync_fill[1] & ~frame_sync);
    end
  end

  assign frame_tick = tick_armed & frame_sync & ~frame_prev;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
      .sysclk    (sysclk),
      .reset     (reset),
      .frame_tick(frame_tick),
      .key_raw   (keys[k]),
      .press     (press[k])
    );
  end

  // Lowest set pending bit, as both an index and a one-hot clear mask
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx       = CODE_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign sel_clear     = (state == IDLE) ? sel_onehot : '0;
  assign press_enabled = press & key_mask;
  assign lost          = |(press_enabled & pending & ~sel_clear);

  // Pending latch and sticky overrun; a fresh press outlives a same-cycle selection
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~sel_clear) | press_enabled;
      if (lost) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Service FSM: raise irq with the selected code, hold until ack, then one gap cycle
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      irq      <= 1'b0;
      irq_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            irq      <= 1'b1;
            irq_code <= sel_idx;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (irq_ack) begin
            irq   <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
